comp_serial: RTL and testbench

Sequential N-bit magnitude comparator built on a 2-bit compare slice. It accepts two W-bit operands on a start strobe and scans them MSB-first, one 2-bit digit pair per cycle. It then reports less / equal / greater on the same three-flag encoding as the combinational 2-bit comparator. It sits downstream of the operand registers and upstream of any block consuming one-hot compare flags.

---
 rtl/comp_pkg.sv | 19 +
 rtl/comp_slice2.sv | 14 +
 rtl/comp_serial.sv | 125 ++++++++++++
 tb/tb_comp_serial.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and the one-hot result triple.
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_res_t;

  localparam cmp_res_t RES_NONE = '{lt: 1'b0, eq: 1'b0, gt: 1'b0};
  localparam cmp_res_t RES_EQ   = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};

endpackage

// File: rtl/comp_slice2.sv
// Combinational 2-bit magnitude compare of one digit pair.
module comp_slice2 (
  input  logic [1:0] x_i,
  input  logic [1:0] y_i,
  output logic       lt_o,
  output logic       eq_o,
  output logic       gt_o
);

  assign lt_o = (x_i < y_i);
  assign eq_o = (x_i == y_i);
  assign gt_o = (x_i > y_i);

endmodule

// File: rtl/comp_serial.sv
// Sequential W-bit magnitude comparator scanning one 2-bit digit pair per cycle, MSB first.
module comp_serial
  import comp_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         f1,
  output logic         f2,
  output logic         f3
);

  localparam int unsigned CW = $clog2(W / 2 + 1);

  if ((W < 2) || ((W % 2) != 0)) begin : g_bad_width
    $error("comp_serial: W must be even and at least 2");
  end

  state_e        state_q, state_d;
  logic [W-1:0]  sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dec_q, dec_d;
  cmp_res_t      dres_q, dres_d;
  cmp_res_t      f_q, f_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          s_lt, s_eq, s_gt;
  cmp_res_t      s_res;
  logic          dec_now;
  cmp_res_t      dres_now;

  comp_slice2 u_slice (
    .x_i  (sa_q[W-1 -: 2]),
    .y_i  (sb_q[W-1 -: 2]),
    .lt_o (s_lt),
    .eq_o (s_eq),
    .gt_o (s_gt)
  );

  assign s_res = '{lt: s_lt, eq: s_eq, gt: s_gt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      dres_q  <= RES_NONE;
      f_q     <= RES_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      dres_q  <= dres_d;
      f_q     <= f_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; the first unequal digit decides, later digits are still scanned.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    dec_d    = dec_q;
    dres_d   = dres_q;
    f_d      = f_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dec_now  = dec_q | ~s_eq;
    dres_now = dec_q ? dres_q : s_res;

    case (state_q)
      RUN: begin
        busy_d = 1'b1;
        dec_d  = dec_now;
        dres_d = dres_now;
        sa_d   = sa_q << 2;
        sb_d   = sb_q << 2;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          f_d     = dec_now ? dres_now : RES_EQ;
        end
      end
      default: begin
        if (start) begin
          state_d = RUN;
          sa_d    = a;
          sb_d    = b;
          cnt_d   = CW'(W / 2);
          dec_d   = 1'b0;
          dres_d  = RES_NONE;
          f_d     = RES_NONE;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign f1   = f_q.lt;
  assign f2   = f_q.eq;
  assign f3   = f_q.gt;

endmodule

// File: tb/tb_comp_serial.sv
// Self-checking bench for comp_serial: directed and random scans at W=8, exhaustive sweep at W=2.
module tb_comp_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done, f1, f2, f3;

  logic       start2;
  logic [1:0] a2, b2;
  logic       busy2, done2, g1, g2, g3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  comp_serial #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .f1(f1), .f2(f2), .f3(f3)
  );

  comp_serial #(.W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .f1(g1), .f2(g2), .f3(g3)
  );

  function automatic logic [2:0] ref_cmp(input int unsigned x, input int unsigned y);
    return {x < y, x == y, x > y};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a start at the next edge (edge 0) and check the capture cycle.
  task automatic go(input logic [7:0] x, input logic [7:0] y);
    start = 1'b1;
    a = x;
    b = y;
    tick();
    chk("edge0_busy", 32'(busy), 32'd1);
    chk("edge0_done", 32'(done), 32'd0);
    chk("edge0_f", 32'({f1, f2, f3}), 32'd0);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  // Run edges 1..4, optionally hammering start with junk operands during RUN.
  task automatic finish(input logic [2:0] exp, input bit spam);
    for (int k = 1; k < 4; k++) begin
      if (spam) begin
        start = 1'b1;
        a = 8'($urandom);
        b = 8'($urandom);
      end
      tick();
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_done", 32'(done), 32'd0);
    end
    start = 1'b0;
    tick();
    chk("edge4_busy", 32'(busy), 32'd0);
    chk("edge4_done", 32'(done), 32'd1);
    chk("edge4_f", 32'({f1, f2, f3}), 32'(exp));
  endtask

  task automatic settle(input logic [2:0] exp);
    tick();
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("hold_f", 32'({f1, f2, f3}), 32'(exp));
  endtask

  initial begin
    logic [7:0] x, y;
    logic [2:0] e;
    bit spam;

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    start2 = 1'b0;
    a2 = '0;
    b2 = '0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_f", 32'({f1, f2, f3}), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    go(8'h5A, 8'h5A);  finish(3'b010, 1'b0);  settle(3'b010);
    go(8'h80, 8'h7F);  finish(3'b001, 1'b0);  settle(3'b001);
    go(8'h03, 8'h02);  finish(3'b001, 1'b0);  settle(3'b001);
    go(8'h02, 8'h03);  finish(3'b100, 1'b0);  settle(3'b100);

    // Start spammed during RUN must not disturb the captured operands.
    go(8'h41, 8'hC0);  finish(3'b100, 1'b1);  settle(3'b100);

    // Start in the DONE cycle chains straight into a second scan.
    go(8'hF0, 8'h0F);  finish(3'b001, 1'b0);
    go(8'h11, 8'h11);  finish(3'b010, 1'b0);
    tick();
    chk("chain_no_double_done", 32'(done), 32'd0);

    // Reset in the middle of a scan aborts it without a done pulse.
    go(8'h12, 8'h34);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("abort_f", 32'({f1, f2, f3}), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
    end
    go(8'h34, 8'h12);  finish(3'b001, 1'b0);  settle(3'b001);

    for (int n = 0; n < 30; n++) begin
      x = 8'($urandom);
      y = (n % 4 == 0) ? x : 8'($urandom);
      if (n % 5 == 1) y = x ^ 8'h01;
      spam = 1'($urandom);
      e = ref_cmp(int'(x), int'(y));
      go(x, y);
      finish(e, spam);
      if (n % 3 != 0) settle(e);
    end

    // Exhaustive W=2 sweep, back-to-back starts at latency 1.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        start2 = 1'b1;
        a2 = 2'(i);
        b2 = 2'(j);
        tick();
        chk("w2_busy", 32'(busy2), 32'd1);
        chk("w2_f_cleared", 32'({g1, g2, g3}), 32'd0);
        start2 = 1'b0;
        tick();
        chk("w2_done", 32'(done2), 32'd1);
        chk("w2_f", 32'({g1, g2, g3}), 32'(ref_cmp(i, j)));
      end
    end
    tick();
    chk("w2_idle_done", 32'(done2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
